// File: rtl/seg_display_decoder.sv
// Receive-side monitor for the two-digit multiplexed seven-segment bus.
// Debounces each scanned digit, decodes it back to BCD and reports complete frames.
module seg_display_decoder #(
  parameter int STABLE_CYCLES  = 2,
  parameter int TIMEOUT        = 64,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic [6:0] DISP,
  input  logic [1:0] DISP_D,
  output logic [7:0] NUM_OUT,
  output logic       NUM_VALID,
  output logic       NUM_CHANGED,
  output logic       SEG_ERR,
  output logic       SCAN_STALL
);

  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [1:0] SEL_ONES  = 2'b10;
  localparam logic [1:0] SEL_TENS  = 2'b01;
  localparam logic [1:0] SEL_BLANK = 2'b11;
  localparam logic [1:0] SEL_ILL   = 2'b00;

  typedef enum logic [1:0] {IDLE, SETTLE, HELD} st_t;

  typedef struct packed {
    logic       ok;
    logic [3:0] bcd;
  } dec_t;

  function automatic dec_t seg_decode(input logic [6:0] p);
    dec_t d;
    d.ok = 1'b1;
    unique case (p)
      7'h3F:   d.bcd = 4'd0;
      7'h06:   d.bcd = 4'd1;
      7'h5B:   d.bcd = 4'd2;
      7'h4F:   d.bcd = 4'd3;
      7'h66:   d.bcd = 4'd4;
      7'h6D:   d.bcd = 4'd5;
      7'h7D:   d.bcd = 4'd6;
      7'h07:   d.bcd = 4'd7;
      7'h7F:   d.bcd = 4'd8;
      7'h6F:   d.bcd = 4'd9;
      default: begin d.ok = 1'b0; d.bcd = 4'd0; end
    endcase
    return d;
  endfunction

  logic [6:0]    s_seg, p_seg;
  logic [1:0]    s_sel, p_sel;
  st_t           state;
  logic [SW-1:0] stab_cnt;
  logic [TW-1:0] stall_cnt, stall_nxt;
  logic [3:0]    ones_buf, tens_buf;
  logic          have_ones, have_tens;

  logic sel_chg, seg_chg, sel_ok, capture, cap_ok, frame;
  dec_t dec;

  always_comb begin
    sel_chg = (s_sel != p_sel);
    seg_chg = (s_seg != p_seg);
    sel_ok  = (s_sel == SEL_ONES) || (s_sel == SEL_TENS);
    dec     = seg_decode(SEG_ACTIVE_LOW ? ~s_seg : s_seg);
    // capture only once the sampled bus has held for STABLE_CYCLES cycles
    capture = (state == SETTLE) && sel_ok && !sel_chg && !seg_chg &&
              (stab_cnt == SW'(STABLE_CYCLES));
    cap_ok  = capture && dec.ok;
    frame   = have_ones && have_tens;
    if (sel_chg)                       stall_nxt = '0;
    else if (stall_cnt != TW'(TIMEOUT)) stall_nxt = stall_cnt + 1'b1;
    else                               stall_nxt = stall_cnt;
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      s_seg       <= '0;
      p_seg       <= '0;
      s_sel       <= SEL_BLANK;
      p_sel       <= SEL_BLANK;
      state       <= IDLE;
      stab_cnt    <= '0;
      stall_cnt   <= '0;
      ones_buf    <= '0;
      tens_buf    <= '0;
      have_ones   <= 1'b0;
      have_tens   <= 1'b0;
      NUM_OUT     <= '0;
      NUM_VALID   <= 1'b0;
      NUM_CHANGED <= 1'b0;
      SEG_ERR     <= 1'b0;
      SCAN_STALL  <= 1'b0;
    end else begin
      s_seg <= DISP;
      s_sel <= DISP_D;
      p_seg <= s_seg;
      p_sel <= s_sel;

      if (sel_chg || seg_chg)                  stab_cnt <= SW'(1);
      else if (stab_cnt != SW'(STABLE_CYCLES)) stab_cnt <= stab_cnt + 1'b1;

      if (sel_chg)                         state <= sel_ok ? SETTLE : IDLE;
      else if (capture)                    state <= HELD;
      else if (state == HELD && seg_chg)   state <= SETTLE;

      SEG_ERR <= (sel_chg && s_sel == SEL_ILL) || (capture && !dec.ok);

      if (cap_ok && s_sel == SEL_ONES) ones_buf <= dec.bcd;
      if (cap_ok && s_sel == SEL_TENS) tens_buf <= dec.bcd;
      // a capture in the completing cycle belongs to the next frame
      have_ones <= (have_ones && !frame) || (cap_ok && s_sel == SEL_ONES);
      have_tens <= (have_tens && !frame) || (cap_ok && s_sel == SEL_TENS);

      NUM_VALID   <= frame;
      NUM_CHANGED <= frame && ({tens_buf, ones_buf} != NUM_OUT);
      if (frame) NUM_OUT <= {tens_buf, ones_buf};

      stall_cnt  <= stall_nxt;
      SCAN_STALL <= (stall_nxt == TW'(TIMEOUT));
    end
  end

endmodule
